// File: rtl/apb_scratch_regfile.sv
// APB slave with a bank of scratch registers, programmable wait states and
// PSLVERR on writes above the bank; reads above the bank return their own address.
module apb_scratch_regfile #(
    parameter int unsigned       ADDR_W      = 5,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       DEPTH       = 16,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PSEL,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);
    localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              access;
    logic              complete;
    logic              in_range;
    logic              wr_en;
    logic [DATA_W-1:0] rd_mem;

    assign access   = PSEL & PENABLE;
    assign in_range = {1'b0, PADDR} < DEPTH_L;
    assign PREADY   = access & (wcnt_q == WS_L) & rst_n;
    assign complete = PREADY;
    assign wr_en    = complete & PWRITE & in_range;

    // wcnt never passes WAIT_STATES: reaching it completes the transfer and clears it
    always_comb begin
        wcnt_d = '0;
        if (access && (wcnt_q != WS_L)) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (PADDR == ADDR_W'(i))) begin
                mem_d[i] = PWDATA;
            end
        end
    end

    always_comb begin
        rd_mem = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (PADDR == ADDR_W'(i)) begin
                rd_mem = mem_q[i];
            end
        end
    end

    // Above the bank the address itself is reflected, resized to the data width
    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (complete) begin
            if (PWRITE) begin
                PSLVERR = ~in_range;
            end else begin
                PRDATA = in_range ? rd_mem : DATA_W'(PADDR);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_VALUE;
            end
        end else begin
            wcnt_q <= wcnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
